time_window_scheduler: RTL and testbench



---
 rtl/time_sched_pkg.sv | 15 +
 rtl/time_sched_fifo.sv | 63 ++++++
 rtl/time_window_scheduler.sv | 151 +++++++++++++++
 tb/tb_time_window_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_sched_pkg.sv
// Shared types and constants for the time window scheduler.
package time_sched_pkg;

   localparam int unsigned CHAN_W  = 5;   // wide enough to index up to 32 channels
   localparam int unsigned LATE_CW = 16;

   typedef struct packed {
      logic [63:0]       ev_time;
      logic [CHAN_W-1:0] chan;
      logic              set;
   } sched_event_t;

   typedef enum logic {ST_IDLE, ST_ARMED} sched_state_e;

endpackage

// File: rtl/time_sched_fifo.sv
// Single-clock event FIFO with synchronous reset and clear; read data is the current head.
module time_sched_fifo #(
   parameter  int unsigned Width = 8,
   parameter  int unsigned Depth = 16,
   localparam int unsigned AW    = $clog2(Depth),
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CntW-1:0]  count
);

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/time_window_scheduler.sv
// Timestamp-driven channel enable sequencer fed by a FIFO of set/clear events.
// Optional build macro TIME_SCHED_LATE_DROP_EN drops late events and exposes late_count.
module time_window_scheduler
   import time_sched_pkg::*;
#(
   parameter  int unsigned NUM_CH = 4,
   parameter  int unsigned DEPTH  = 16,
   localparam int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CW     = $clog2(DEPTH + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       current_time,
   input  logic              time_running,
   input  logic              ev_valid,
   output logic              ev_ready,
   input  logic [63:0]       ev_time,
   input  logic [CHW-1:0]    ev_chan,
   input  logic              ev_set,
   input  logic              flush,
   output logic [NUM_CH-1:0] ch_enable,
   output logic              fire_pulse,
   output logic              busy,
   output logic [CW-1:0]     pending
`ifdef TIME_SCHED_LATE_DROP_EN
   ,
   output logic [LATE_CW-1:0] late_count
`endif
);

   localparam int unsigned FifoCntW = $clog2(DEPTH + 1);

   sched_state_e         state_q, state_d;
   sched_event_t         head_q, head_d;
   sched_event_t         wr_event, fifo_head;
   logic [NUM_CH-1:0]    ch_en_q, ch_en_d;
   logic                 fire_q, fire_d;
   logic                 fifo_pop, fifo_push, fifo_full, fifo_empty;
   logic [$bits(sched_event_t)-1:0] fifo_rdata;
   logic [FifoCntW-1:0]  fifo_count;

`ifdef TIME_SCHED_LATE_DROP_EN
   logic                 head_late_q, head_late_d;
   logic [LATE_CW-1:0]   late_cnt_q, late_cnt_d;
   assign late_count = late_cnt_q;
`endif

   assign ev_ready  = !fifo_full && !flush && !rst;
   assign fifo_push = ev_valid && ev_ready;
   assign fifo_head = sched_event_t'(fifo_rdata);

   always_comb begin
      wr_event.ev_time = ev_time;
      wr_event.chan    = CHAN_W'(ev_chan);
      wr_event.set     = ev_set;
   end

   time_sched_fifo #(
      .Width ($bits(sched_event_t)),
      .Depth (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (wr_event),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d  = state_q;
      head_d   = head_q;
      ch_en_d  = ch_en_q;
      fire_d   = 1'b0;
      fifo_pop = 1'b0;
`ifdef TIME_SCHED_LATE_DROP_EN
      head_late_d = head_late_q;
      late_cnt_d  = late_cnt_q;
`endif
      if (flush) begin
         state_d = ST_IDLE;
         ch_en_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  head_d   = fifo_head;
                  state_d  = ST_ARMED;
`ifdef TIME_SCHED_LATE_DROP_EN
                  head_late_d = time_running && (current_time > fifo_head.ev_time);
`endif
               end
            end
            ST_ARMED: begin
`ifdef TIME_SCHED_LATE_DROP_EN
               if (head_late_q) begin
                  state_d = ST_IDLE;
                  if (late_cnt_q != '1) late_cnt_d = late_cnt_q + 1'b1;
               end else
`endif
               if (time_running && (current_time >= head_q.ev_time)) begin
                  state_d = ST_IDLE;
                  fire_d  = 1'b1;
                  // Out-of-range channels match nothing but still pulse.
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (head_q.chan == CHAN_W'(i)) ch_en_d[i] = head_q.set;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         head_q  <= '0;
         ch_en_q <= '0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         ch_en_q <= ch_en_d;
         fire_q  <= fire_d;
      end
   end

`ifdef TIME_SCHED_LATE_DROP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         head_late_q <= 1'b0;
         late_cnt_q  <= '0;
      end else begin
         head_late_q <= head_late_d;
         late_cnt_q  <= late_cnt_d;
      end
   end
`endif

   assign ch_enable  = ch_en_q;
   assign fire_pulse = fire_q;
   assign busy       = (state_q != ST_IDLE) || !fifo_empty;
   assign pending    = CW'(fifo_count) + CW'(state_q == ST_ARMED);

endmodule

// File: tb/tb_time_window_scheduler.sv
// Scoreboard bench for time_window_scheduler with a queue-based timing reference model.
module tb_time_window_scheduler;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CHW    = 2;
   localparam int unsigned CW     = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [63:0]       current_time = '0;
   logic              time_running = 1'b0;
   logic              ev_valid = 1'b0;
   logic              ev_ready;
   logic [63:0]       ev_time = '0;
   logic [CHW-1:0]    ev_chan = '0;
   logic              ev_set = 1'b0;
   logic              flush = 1'b0;
   logic [NUM_CH-1:0] ch_enable;
   logic              fire_pulse;
   logic              busy;
   logic [CW-1:0]     pending;

   time_window_scheduler #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .current_time (current_time),
      .time_running (time_running),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_time      (ev_time),
      .ev_chan      (ev_chan),
      .ev_set       (ev_set),
      .flush        (flush),
      .ch_enable    (ch_enable),
      .fire_pulse   (fire_pulse),
      .busy         (busy),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Pending event: earl is the earliest edge it may fire once it is the queue head.
   typedef struct {
      logic [63:0] t;
      int          ch;
      bit          s;
      int          pe;
      int          earl;
   } mev_t;

   typedef struct {
      int                edge_no;
      logic [NUM_CH-1:0] en;
   } exp_t;

   mev_t              mq[$];
   exp_t              exp_q[$];
   logic [NUM_CH-1:0] m_en = '0;
   int                last_fire = -10;
   logic [63:0]       tnow = '0;
   int                total = 0;
   int                bad = 0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at edge %0d: got=%0h want=%0h", name, edge_cnt, got, want);
      end
   endtask

   // One clock: check outputs of the previous edge, drive inputs, predict the next edge.
   task automatic step(input bit v, input logic [63:0] t, input int ch, input bit s,
                       input bit fl, input bit rs, input bit run);
      int   k;
      bit   armed;
      bit   rdy;
      mev_t e;
      @(negedge clk);
      chk("pending", 64'(pending), 64'(mq.size()));
      chk("busy", 64'(busy), 64'(mq.size() > 0));
      chk("ch_enable", 64'(ch_enable), 64'(m_en));
      ev_valid     = v;
      ev_time      = t;
      ev_chan      = CHW'(ch);
      ev_set       = s;
      flush        = fl;
      rst          = rs;
      time_running = run;
      current_time = tnow;
      #1;
      k     = edge_cnt + 1;
      armed = (mq.size() > 0) && (k >= mq[0].earl);
      rdy   = !fl && !rs && ((mq.size() - int'(armed)) < int'(DEPTH));
      chk("ev_ready", 64'(ev_ready), 64'(rdy));
      if (fl || rs) begin
         mq.delete();
         m_en      = '0;
         last_fire = -10;
      end else begin
         if (armed && run && (tnow >= mq[0].t)) begin
            if (mq[0].ch < int'(NUM_CH)) m_en[mq[0].ch] = mq[0].s;
            exp_q.push_back('{edge_no: k, en: m_en});
            void'(mq.pop_front());
            last_fire = k;
            if (mq.size() > 0) mq[0].earl = max2(mq[0].pe + 2, k + 2);
         end
         if (v && rdy) begin
            e = '{t: t, ch: ch, s: s, pe: k, earl: max2(k + 2, last_fire + 2)};
            mq.push_back(e);
         end
      end
      if (run) tnow = tnow + 1;
   endtask

   task automatic idle(input int n, input bit run);
      repeat (n) step(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, run);
   endtask

   task automatic do_flush(input bit v);
      step(v, 64'd5, 1, 1'b1, 1'b1, 1'b0, 1'b1);
   endtask

   // Monitor: every fire_pulse must match the oldest expected fire, on the predicted edge.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (fire_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL fire_unexpected at edge %0d: got fire_pulse=1 want 0", edge_cnt);
            end else begin
               x = exp_q.pop_front();
               chk("fire_edge", 64'(edge_cnt), 64'(x.edge_no));
               chk("fire_enable", 64'(ch_enable), 64'(x.en));
            end
         end else if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
            x = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL fire_missing at edge %0d: got no pulse want pulse for edge %0d",
                     edge_cnt, x.edge_no);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] ts;
      // Reset, then first cycle after release.
      step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0);

      // Basic future fire with a continuous count.
      tnow = 64'd100;
      step(1'b1, 64'd150, 1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(55, 1'b1);
      chk("basic_en", 64'(ch_enable), 64'h2);

      // Past timestamp latency.
      tnow = 64'd500;
      step(1'b1, 64'd10, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(4, 1'b1);

      // Equal timestamps fire in push order.
      do_flush(1'b0);
      tnow = 64'd190;
      step(1'b1, 64'd200, 2, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 64'd200, 2, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 64'd200, 3, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(20, 1'b1);
      chk("eq_time_final", 64'(ch_enable), 64'h8);

      // Backpressure with far-future events.
      do_flush(1'b0);
      tnow = 64'd1000;
      for (int i = 0; i < 18; i++) begin
         step(1'b1, 64'hFFFF_FFFF_0000_0000, i % 4, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      idle(1, 1'b1);
      chk("bp_pending", 64'(pending), 64'd17);

      // Flush and reset mid-operation with ch_enable = 0011 and 5 pending.
      for (int pass = 0; pass < 2; pass++) begin
         do_flush(1'b0);
         step(1'b1, 64'd0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
         step(1'b1, 64'd0, 1, 1'b1, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 5; i++) begin
            step(1'b1, 64'hFFFF_FFFF_FFFF_0000, i % 4, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         idle(4, 1'b1);
         chk("pre_flush_en", 64'(ch_enable), 64'h3);
         if (pass == 0) do_flush(1'b1);
         else step(1'b1, 64'd5, 1, 1'b1, 1'b0, 1'b1, 1'b1);
         idle(1, 1'b1);
         chk("post_clear_pending", 64'(pending), 64'd0);
         chk("post_clear_en", 64'(ch_enable), 64'd0);
      end

      // Time stopped holds the head.
      do_flush(1'b0);
      tnow = 64'd60;
      step(1'b1, 64'd50, 2, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(20, 1'b0);
      chk("stopped_pending", 64'(pending), 64'd1);
      idle(3, 1'b1);

      // Randomized traffic, occasional flush and timer restart.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 99) == 0) tnow = '0;
         ts = tnow + 64'($urandom_range(0, 40));
         step(1'($urandom_range(0, 1)), ts, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 63) == 0, 1'b0, $urandom_range(0, 9) != 0);
      end
      idle(3, 1'b1);
      @(negedge clk);
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
